vga_frame_reader: RTL and testbench
===================================

// Module: vga_frame_reader
// PURPOSE
//  Display-side consumer of the memory stage's port B (clk_b domain): scans a 640x480@60 VGA raster.
//  Issues port-B word addresses for the 300x300 image window and turns the returned 24-bit words into RGB.
//  Owns raster timing, address generation and read-latency alignment; the memory stage only decodes address_b.
// PARAMETERS
//  H_ACTIVE 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal timing, pixel clocks (total 800)
//  V_ACTIVE 480 / V_FP 10 / V_SYNC 2 / V_BP 33  : vertical timing, lines (total 525)
//  IMG_W 300, IMG_H 300 : image size in pixels, row-major, one 24-bit word per pixel
//  IMG_X0 170, IMG_Y0 90 : top-left of image inside active area
//  IMG_BASE 0 : port-B word address of pixel (0,0); IMG_BASE+IMG_W*IMG_H-1 must be <= 131071
//  READ_LATENCY 1 : clocks from address_b to valid read_data_b (1..4)
// PORTS
//  clk           in   1   pixel clock (25 MHz), sole clock
//  rst           in   1   asynchronous, active-low reset
//  read_data_b   in   24  port-B read data, {R[23:16],G[15:8],B[7:0]}
//  address_b     out  17  port-B word address
//  hsync         out  1   horizontal sync, active low
//  vsync         out  1   vertical sync, active low
//  de            out  1   data enable, high in 640x480 active area
//  r, g, b       out  8   pixel colour; 0 outside image and in blanking
//  frame_start   out  1   1-cycle pulse, coincident with output pixel (0,0)
// BEHAVIOUR
//  - Reset (rst=0, async): h_cnt=v_cnt=0, pix_idx=0, pipeline cleared;
//    outputs hsync=1, vsync=1, de=0, r=g=b=0, frame_start=0, address_b=IMG_BASE.
//  - Stage 0 counters: h_cnt 0..799 wraps to 0; v_cnt increments on the h wrap, 0..524 wraps to 0.
//  - Raw timing: active = h<640 && v<480; hs_n low for h in [656,751]; vs_n low for v in [490,491].
//  - in_img = h in [IMG_X0, IMG_X0+IMG_W) && v in [IMG_Y0, IMG_Y0+IMG_H).
//  - Address: address_b = IMG_BASE + pix_idx, from registered pix_idx; no multiplier.
//  - pix_idx increments by 1 each in_img cycle and holds otherwise; rows are contiguous.
//  - pix_idx clears to 0 on the cycle h=799,v=524, so (0,0) of every frame starts at 0.
//  - pix_idx saturates at IMG_W*IMG_H-1; it never wraps mid-frame.
//  - Alignment: active, hs_n, vs_n, in_img and first_px (h==0&&v==0) are delayed READ_LATENCY stages.
//    A final output register then gives fixed latency READ_LATENCY+1 from counter state to pins.
//  - Output register: r,g,b = delayed in_img ? read_data_b fields : 0; hsync, vsync, de, frame_start from delayed flags.
//  - read_data_b is sampled only when delayed in_img=1; X on it otherwise must not reach r,g,b.
//  - Reset mid-frame: everything returns to the reset state immediately.
//    After release the raster restarts at (0,0) and address_b restarts at IMG_BASE.
//  - No handshake: port B is always read-enabled; one address per clock, free-running.
// STRUCTURE
//  - vga_timing_pkg: timing localparams, H_TOTAL/V_TOTAL and sync start/end derived constants.
//    Also holds typedef rgb888_t (struct r,g,b) and typedef pix_addr_t (logic [16:0]).
//  - Sub-module vga_timing_gen: h/v counters, raw active/hs_n/vs_n/first_px.
//  - Top level: pix_idx, address_b, delay line and output register.
// TESTING (memory model: read_data_b = {7'b0, addr} after READ_LATENCY clocks)
//  - Reset held then released: during reset hsync=1, vsync=1, de=0, rgb=0, address_b=0.
//    First hsync fall is 656+READ_LATENCY+1 clocks after release.
//  - Timing: hsync period 800 / low 96 clocks; vsync period 420000 / low 1600 clocks; de high 640 per line on 480 lines.
//  - Address walk: (x170,y90)->0, (x469,y90)->299, (x170,y91)->300, (x469,y389)->89999.
//    address_b holds 89999 until the next frame, which restarts at 0.
//  - Data alignment: output pixel (170,90) rgb=0x000000 (word 0), pixel (171,90) b=0x01, pixel (469,389) = model(89999).
//    Pixels (169,90) and (170,89) are 0.
//  - READ_LATENCY=3 rebuild: same pin-level pixel/sync relationship, all outputs shifted by +2 clocks.
//  - Reset pulsed 3 clocks at v=200,h=300: outputs go to reset values asynchronously.
//    After release address_b=0 and frame_start pulses exactly once per 420000 clocks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and types for the port-B frame reader.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int IMG_W        = 300;
    localparam int IMG_H        = 300;
    localparam int IMG_X0       = 170;
    localparam int IMG_Y0       = 90;
    localparam int IMG_BASE     = 0;
    localparam int READ_LATENCY = 1;

    // Ten bits covers both totals (800 and 525) with headroom.
    typedef logic [9:0]  cnt_t;
    typedef logic [16:0] pix_addr_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
        logic in_img;
        logic first_px;
    } vid_flags_t;

    localparam vid_flags_t FLAGS_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1,
                                          in_img: 1'b0, first_px: 1'b0};

endpackage

// File: rtl/vga_frame_reader_if.sv
// Port-B read bus between the frame reader and the frame memory.
interface vga_frame_reader_if;
    import vga_timing_pkg::*;

    pix_addr_t   address_b;
    logic [23:0] read_data_b;

    modport master (output address_b, input read_data_b);
    modport slave  (input address_b, output read_data_b);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters and the raw, undelayed timing flags.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP
)(
    input  logic clk,
    input  logic rst,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output logic active,
    output logic hs_n,
    output logic vs_n,
    output logic first_px,
    output logic frame_last
);

    localparam cnt_t H_WRAP  = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_WRAP  = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_ACT_C = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_C = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_FROM = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_TO   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_FROM = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_TO   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_WRAP) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_WRAP) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs_n       = !((h_cnt >= HS_FROM) && (h_cnt < HS_TO));
    assign vs_n       = !((v_cnt >= VS_FROM) && (v_cnt < VS_TO));
    assign first_px   = (h_cnt == '0) && (v_cnt == '0);
    assign frame_last = (h_cnt == H_WRAP) && (v_cnt == V_WRAP);

endmodule

// File: rtl/vga_frame_reader.sv
// Scans the VGA raster, fetches the image window over port B and aligns the
// returned words with the delayed sync/enable flags before driving the pins.
module vga_frame_reader
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE     = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP         = vga_timing_pkg::H_FP,
    parameter int H_SYNC       = vga_timing_pkg::H_SYNC,
    parameter int H_BP         = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE     = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP         = vga_timing_pkg::V_FP,
    parameter int V_SYNC       = vga_timing_pkg::V_SYNC,
    parameter int V_BP         = vga_timing_pkg::V_BP,
    parameter int IMG_W        = vga_timing_pkg::IMG_W,
    parameter int IMG_H        = vga_timing_pkg::IMG_H,
    parameter int IMG_X0       = vga_timing_pkg::IMG_X0,
    parameter int IMG_Y0       = vga_timing_pkg::IMG_Y0,
    parameter int IMG_BASE     = vga_timing_pkg::IMG_BASE,
    parameter int READ_LATENCY = vga_timing_pkg::READ_LATENCY
)(
    input  logic                      clk,
    input  logic                      rst,
    vga_frame_reader_if.master        mem,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic [7:0]                r,
    output logic [7:0]                g,
    output logic [7:0]                b,
    output logic                      frame_start
);

    localparam cnt_t      X_FROM    = cnt_t'(IMG_X0);
    localparam cnt_t      X_TO      = cnt_t'(IMG_X0 + IMG_W);
    localparam cnt_t      Y_FROM    = cnt_t'(IMG_Y0);
    localparam cnt_t      Y_TO      = cnt_t'(IMG_Y0 + IMG_H);
    localparam pix_addr_t PIX_LAST  = pix_addr_t'(IMG_W * IMG_H - 1);
    localparam pix_addr_t BASE_ADDR = pix_addr_t'(IMG_BASE);

    cnt_t       h_cnt, v_cnt;
    logic       active, hs_n, vs_n, first_px, frame_last, in_img;
    pix_addr_t  pix_idx;
    vid_flags_t raw_flags, tail;
    vid_flags_t dly [READ_LATENCY];
    rgb888_t    pix_q;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .hs_n       (hs_n),
        .vs_n       (vs_n),
        .first_px   (first_px),
        .frame_last (frame_last)
    );

    assign in_img = (h_cnt >= X_FROM) && (h_cnt < X_TO) &&
                    (v_cnt >= Y_FROM) && (v_cnt < Y_TO);

    // Rows are contiguous in memory, so a running pixel index replaces x+y*W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pix_idx <= '0;
        else if (frame_last)
            pix_idx <= '0;
        else if (in_img && (pix_idx != PIX_LAST))
            pix_idx <= pix_idx + 1'b1;
    end

    assign mem.address_b = BASE_ADDR + pix_idx;

    assign raw_flags = '{active: active, hs_n: hs_n, vs_n: vs_n,
                         in_img: in_img, first_px: first_px};

    // Flags travel alongside the memory read so they meet the returned word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < READ_LATENCY; i++)
                dly[i] <= FLAGS_IDLE;
        end else begin
            dly[0] <= raw_flags;
            for (int i = 1; i < READ_LATENCY; i++)
                dly[i] <= dly[i-1];
        end
    end

    assign tail = dly[READ_LATENCY-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
            pix_q       <= '0;
        end else begin
            hsync       <= tail.hs_n;
            vsync       <= tail.vs_n;
            de          <= tail.active;
            frame_start <= tail.first_px;
            pix_q       <= tail.in_img ? rgb888_t'(mem.read_data_b) : '0;
        end
    end

    assign r = pix_q.r;
    assign g = pix_q.g;
    assign b = pix_q.b;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scaled-raster bench: two readers (latency 1 and 3) against a raster/scoreboard model.
module tb_vga_frame_reader;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 40, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int IW = 20, IH = 12, IX = 17, IY = 9, BASE = 0;
    localparam int LAT1 = 1, LAT3 = 3;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_frame_reader_if bus1 ();
    vga_frame_reader_if bus3 ();

    logic       hsync1, vsync1, de1, fs1, hsync3, vsync3, de3, fs3;
    logic [7:0] r1, g1, b1, r3, g3, b3;

    vga_frame_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .IMG_W (IW), .IMG_H (IH), .IMG_X0 (IX), .IMG_Y0 (IY),
        .IMG_BASE (BASE), .READ_LATENCY (LAT1)
    ) dut1 (
        .clk (clk), .rst (rst), .mem (bus1),
        .hsync (hsync1), .vsync (vsync1), .de (de1),
        .r (r1), .g (g1), .b (b1), .frame_start (fs1)
    );

    vga_frame_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .IMG_W (IW), .IMG_H (IH), .IMG_X0 (IX), .IMG_Y0 (IY),
        .IMG_BASE (BASE), .READ_LATENCY (LAT3)
    ) dut3 (
        .clk (clk), .rst (rst), .mem (bus3),
        .hsync (hsync3), .vsync (vsync3), .de (de3),
        .r (r3), .g (g3), .b (b3), .frame_start (fs3)
    );

    int checks = 0;
    int failures = 0;
    int mh = 0, mv = 0;
    int since_release = 0;
    int fall1_at = -1, fall3_at = -1;
    int fs_count1 = 0, fs_count3 = 0;
    bit fs_count_on = 1'b0;
    logic [27:0] q1 [$];
    logic [27:0] q3 [$];
    logic [23:0] d1 [$];
    logic [23:0] d3 [$];

    localparam logic [27:0] RESET_PINS = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

    function automatic bit in_img_m(int h, int v);
        return (h >= IX) && (h < IX + IW) && (v >= IY) && (v < IY + IH);
    endfunction

    // Pixels of the window already fetched this frame, capped at the last one.
    function automatic int exp_addr(int h, int v);
        int idx;
        if (v < IY)
            idx = 0;
        else if (v >= IY + IH)
            idx = IW * IH;
        else
            idx = (v - IY) * IW + ((h < IX) ? 0 : ((h >= IX + IW) ? IW : h - IX));
        if (idx > IW * IH - 1)
            idx = IW * IH - 1;
        return BASE + idx;
    endfunction

    function automatic logic [27:0] exp_pins(int h, int v);
        logic [23:0] px;
        px = in_img_m(h, v) ? 24'(exp_addr(h, v)) : 24'h0;
        return {!((h >= HA + HF) && (h < HA + HF + HS)),
                !((v >= VA + VF) && (v < VA + VF + VS)),
                (h < HA) && (v < VA), (h == 0) && (v == 0), px};
    endfunction

    task automatic check_value(string tag, logic [27:0] obs, logic [27:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h (h=%0d v=%0d)", tag, obs, expv, mh, mv);
        end
    endtask

    // One sample per clock: check address, score delayed pins, feed memory model.
    task automatic check_output();
        logic [27:0] e;
        e = exp_pins(mh, mv);
        check_value("addr1", 28'(bus1.address_b), 28'(exp_addr(mh, mv)));
        check_value("addr3", 28'(bus3.address_b), 28'(exp_addr(mh, mv)));
        if (mh == IX && mv == IY)
            check_value("addr_first", 28'(bus1.address_b), 28'(BASE));
        if (mh == IX + IW - 1 && mv == IY)
            check_value("addr_row_end", 28'(bus1.address_b), 28'(BASE + IW - 1));
        if (mh == IX && mv == IY + 1)
            check_value("addr_row2", 28'(bus1.address_b), 28'(BASE + IW));
        if (mh == IX + IW - 1 && mv == IY + IH - 1)
            check_value("addr_last", 28'(bus1.address_b), 28'(BASE + IW * IH - 1));
        if (mh == HT - 1 && mv == VT - 1)
            check_value("addr_hold", 28'(bus1.address_b), 28'(BASE + IW * IH - 1));
        q1.push_back(e);
        q3.push_back(e);
        if (q1.size() > LAT1 + 1)
            check_value("pins1", {hsync1, vsync1, de1, fs1, r1, g1, b1}, q1.pop_front());
        if (q3.size() > LAT3 + 1)
            check_value("pins3", {hsync3, vsync3, de3, fs3, r3, g3, b3}, q3.pop_front());
        d1.push_back(in_img_m(mh, mv) ? {7'b0, bus1.address_b} : 24'bx);
        d3.push_back(in_img_m(mh, mv) ? {7'b0, bus3.address_b} : 24'bx);
        bus1.read_data_b = (d1.size() > LAT1) ? d1.pop_front() : 24'bx;
        bus3.read_data_b = (d3.size() > LAT3) ? d3.pop_front() : 24'bx;
    endtask

    task automatic apply_stimulus(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
            since_release++;
            if (fall1_at < 0 && hsync1 === 1'b0) fall1_at = since_release;
            if (fall3_at < 0 && hsync3 === 1'b0) fall3_at = since_release;
            if (fs_count_on) begin
                fs_count1 += int'(fs1);
                fs_count3 += int'(fs3);
            end
            check_output();
        end
    endtask

    task automatic check_reset_state(string tag);
        check_value({tag, "_pins1"}, {hsync1, vsync1, de1, fs1, r1, g1, b1}, RESET_PINS);
        check_value({tag, "_pins3"}, {hsync3, vsync3, de3, fs3, r3, g3, b3}, RESET_PINS);
        check_value({tag, "_addr1"}, 28'(bus1.address_b), 28'(BASE));
        check_value({tag, "_addr3"}, 28'(bus3.address_b), 28'(BASE));
    endtask

    // Called just after a falling edge, so the raster holds (0,0) until the next rise.
    task automatic release_reset();
        rst = 1'b1;
        mh = 0;
        mv = 0;
        since_release = 0;
        fall1_at = -1;
        fall3_at = -1;
        q1.delete(); q3.delete(); d1.delete(); d3.delete();
        check_output();
    endtask

    initial begin
        bus1.read_data_b = 24'bx;
        bus3.read_data_b = 24'bx;
        repeat (4) @(negedge clk);
        check_reset_state("reset_hold");
        release_reset();

        apply_stimulus(HA + HF + LAT3 + 4);
        check_value("hs_fall1", 28'(fall1_at), 28'(HA + HF + LAT1 + 1));
        check_value("hs_fall3", 28'(fall3_at), 28'(HA + HF + LAT3 + 1));

        apply_stimulus(2 * FRAME + 20 * HT + 30 - (HA + HF + LAT3 + 4));

        // Mid-frame reset at v=20,h=30 must act without waiting for a clock edge.
        #2 rst = 1'b0;
        #1 check_reset_state("reset_async");
        repeat (3) @(negedge clk);
        check_reset_state("reset_mid");
        release_reset();

        apply_stimulus(10);
        fs_count_on = 1'b1;
        apply_stimulus(FRAME);
        fs_count_on = 1'b0;
        check_value("fs_once1", 28'(fs_count1), 28'd1);
        check_value("fs_once3", 28'(fs_count3), 28'd1);
        check_value("hs_refall1", 28'(fall1_at), 28'(HA + HF + LAT1 + 1));
        check_value("hs_refall3", 28'(fall3_at), 28'(HA + HF + LAT3 + 1));

        apply_stimulus(FRAME / 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
